// File: rtl/tick_ctrl.sv
// Tick controller: two debounced buttons drive an IDLE/RUN/PAUSE FSM that issues
// one-cycle tick pulses, either periodically in RUN or as single steps.
module tick_ctrl #(
  parameter int unsigned DIVISOR   = 4,
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic       tick,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] PMax = PW'(DIVISOR - 1);
  localparam logic [7:0] DbMax = 8'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  // Bit 0 is the run button, bit 1 the step button.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] db_q, db_prev_q;
  logic [7:0] db_cnt_q [2];
  logic       run_ev, step_ev;

  state_e        state_q;
  logic [PW-1:0] presc_q;

  assign btn_raw = {btn_step, btn_run};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbMax) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Press events fire the cycle after the debounced level rises.
  assign run_ev  = db_q[0] & ~db_prev_q[0];
  assign step_ev = db_q[1] & ~db_prev_q[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
    end else begin
      tick <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run_ev) begin
            state_q <= StRun;
            presc_q <= '0;
            running <= 1'b1;
          end else if (step_ev) begin
            tick <= 1'b1;
          end
        end
        StRun: begin
          // A pausing cycle leaves the prescaler untouched.
          if (run_ev) begin
            state_q <= StPause;
            running <= 1'b0;
          end else if (presc_q == PMax) begin
            presc_q <= '0;
            tick    <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        StPause: begin
          if (run_ev) begin
            state_q <= StRun;
            running <= 1'b1;
          end else if (step_ev) begin
            tick <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          presc_q <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_tick_ctrl.sv
// Bench for tick_ctrl: directed vector table, hand-written corner sequences and a
// randomized phase compared cycle by cycle against a behavioural model.
module tb_tick_ctrl;

  localparam int unsigned Div = 4;
  localparam int unsigned Db  = 3;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       btn_run  = 1'b0;
  logic       btn_step = 1'b0;
  logic       tick;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  tick_ctrl #(
    .DIVISOR  (Div),
    .DB_CYCLES(Db)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_run (btn_run),
    .btn_step(btn_step),
    .tick    (tick),
    .running (running),
    .state   (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: raw history queue for the synchronizer delay, run-length
  // counting for the debounce, and a count of RUN cycles for the tick period.
  logic [1:0] hq[$];
  logic [1:0] m_lvl  = '0;
  logic [1:0] m_rise = '0;
  logic [1:0] m_syn, m_ev;
  int         m_diff[2];
  int         m_mode = 0;
  int         m_cnt  = 0;
  logic       m_tick = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      hq.delete();
      m_lvl  = '0;
      m_rise = '0;
      m_diff = '{0, 0};
      m_mode = 0;
      m_cnt  = 0;
      m_tick = 1'b0;
    end else begin
      m_ev  = m_rise;
      m_syn = (hq.size() >= 2) ? hq[hq.size()-2] : 2'b00;
      hq.push_back({btn_step, btn_run});
      if (hq.size() > 2) void'(hq.pop_front());
      m_rise = '0;
      for (int i = 0; i < 2; i++) begin
        if (m_syn[i] != m_lvl[i]) begin
          m_diff[i]++;
          if (m_diff[i] == int'(Db)) begin
            m_rise[i] = m_syn[i];
            m_lvl[i]  = m_syn[i];
            m_diff[i] = 0;
          end
        end else begin
          m_diff[i] = 0;
        end
      end
      m_tick = 1'b0;
      case (m_mode)
        0: if (m_ev[0]) begin m_mode = 1; m_cnt = 0; end
           else if (m_ev[1]) m_tick = 1'b1;
        1: if (m_ev[0]) m_mode = 2;
           else begin
             m_cnt++;
             if (m_cnt == int'(Div)) begin m_tick = 1'b1; m_cnt = 0; end
           end
        default: if (m_ev[0]) m_mode = 1;
                 else if (m_ev[1]) m_tick = 1'b1;
      endcase
    end
  end

  function automatic int outs();
    return int'({state, running, tick});
  endfunction

  function automatic int exp_o(input int st, input bit tk);
    return st * 4 + ((st == 1) ? 2 : 0) + (tk ? 1 : 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst_n;
    bit run;
    bit step;
    int n;
    int st;
    bit tk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit b, input bit s, input int n, input int st,
                     input bit tk);
    vec_t v;
    v = '{r, b, s, n, st, tk};
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int nticks;
    int hr;
    int hs;

    // Run held 10 cycles: RUN after 6, ticks 4/8/12 later.
    add(0, 0, 0, 2, 0, 0);
    add(1, 1, 0, 5, 0, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 3, 1, 0);
    add(1, 1, 0, 1, 1, 1);
    add(1, 0, 0, 3, 1, 0);
    add(1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 3, 1, 0);
    add(1, 0, 0, 1, 1, 1);
    // Two-cycle bounce is rejected.
    add(0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 2, 0, 0);
    add(1, 0, 0, 10, 0, 0);
    // Run and step together: run wins, no step tick.
    add(1, 1, 1, 5, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 2, 1, 0);
    add(1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 3, 1, 0);
    // Reset with prescaler at 3, then re-enter RUN.
    add(0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 3, 0, 0);
    add(1, 1, 0, 5, 0, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 0, 0, 3, 1, 0);
    add(1, 0, 0, 1, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst      = tbl[i].rst_n;
      btn_run  = tbl[i].run;
      btn_step = tbl[i].step;
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc();
        chk($sformatf("vec%0d", i), outs(), exp_o(tbl[i].st, tbl[i].tk));
      end
    end

    // Pause two cycles after a tick, hold 20 cycles, resume.
    cyc();
    chk("pause_pre", outs(), exp_o(1, 0));
    btn_run = 1'b1;
    for (int i = 2; i <= 6; i++) begin
      cyc();
      chk("pause_run", outs(), exp_o(1, i == 4));
    end
    cyc();
    chk("pause_enter", outs(), exp_o(2, 0));
    for (int i = 0; i < 20; i++) begin
      if (i == 3) btn_run = 1'b0;
      cyc();
      chk("pause_hold", outs(), exp_o(2, 0));
    end
    btn_run = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
      if (!running) chk("resume_wait", outs(), exp_o(2, 0));
    end while (!running && n < 12);
    chk("resume_lat", n, 6);
    cyc();
    chk("resume_t1", outs(), exp_o(1, 0));
    cyc();
    chk("resume_t2", outs(), exp_o(1, 1));
    btn_run = 1'b0;

    // Three step presses in IDLE.
    rst = 1'b0;
    cyc();
    chk("rst_idle", outs(), exp_o(0, 0));
    rst = 1'b1;
    nticks = 0;
    for (int p = 0; p < 3; p++) begin
      btn_step = 1'b1;
      for (int i = 1; i <= 13; i++) begin
        if (i == 6) btn_step = 1'b0;
        cyc();
        if (tick) nticks++;
        chk("step", outs(), exp_o(0, i == 6));
      end
    end
    chk("step_count", nticks, 3);

    // Run button held through reset.
    rst     = 1'b0;
    btn_run = 1'b1;
    repeat (3) begin
      cyc();
      chk("held_rst", outs(), exp_o(0, 0));
    end
    rst = 1'b1;
    n   = 0;
    do begin
      cyc();
      n++;
      if (n == 1) chk("post_rst_tick", outs(), exp_o(0, 0));
    end while (!running && n < 12);
    chk("held_lat", n, 6);
    btn_run = 1'b0;

    // Randomized phase against the model.
    rst = 1'b0;
    cyc();
    chk("rand_rst", outs(), exp_o(m_mode, m_tick));
    hr = 0;
    hs = 0;
    for (int c = 0; c < 2500; c++) begin
      if (hr == 0) begin
        btn_run = 1'($urandom_range(0, 1));
        hr      = int'($urandom_range(1, 9));
      end
      if (hs == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        hs       = int'($urandom_range(1, 9));
      end
      hr--;
      hs--;
      rst = ($urandom_range(0, 249) != 0);
      cyc();
      chk("rand", outs(), exp_o(m_mode, m_tick));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 Parameter DIVISOR, default 4: RUN-state tick period in clk cycles; legal range 1..65535.
REQ-002 Parameter DB_CYCLES, default 3: consecutive stable samples required to accept a button level change; legal range 1..255.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port btn_run  input  1  raw asynchronous run/pause button, active-high.
REQ-006 Port btn_step  input  1  raw asynchronous single-step button, active-high.
REQ-007 Port tick  output  1  registered one-cycle enable pulse to the downstream counter's increment.
REQ-008 Port running  output  1  high exactly while state is RUN.
REQ-009 Port state  output  2  current FSM state encoding: IDLE=00, RUN=01, PAUSE=10; 11 unused.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce, per button: a counter advances while the synchronized value differs from the debounced level and clears whenever they match.
REQ-012 When the synchronized value has differed from the debounced level for DB_CYCLES consecutive cycles, the debounced level takes the new value and the counter clears.
REQ-013 Press event: a one-cycle internal pulse on each 0->1 transition of a debounced level; releases generate no event.
REQ-014 FSM states: IDLE, RUN, PAUSE; one transition per cycle at most.
REQ-015 IDLE: run event -> RUN with prescaler cleared to 0; step event -> stay IDLE and issue one step tick.
REQ-016 RUN: the prescaler increments every cycle, modulo DIVISOR; tick is asserted in the cycle after the prescaler equals DIVISOR-1, and the prescaler wraps to 0.
REQ-017 RUN: first tick occurs DIVISOR cycles after the first cycle in RUN; subsequent ticks occur every DIVISOR cycles.
REQ-018 RUN: run event -> PAUSE with the prescaler frozen at its current value; step events are ignored.
REQ-019 PAUSE: run event -> RUN with the prescaler resuming from its frozen value; step event -> stay PAUSE, issue one step tick, prescaler unchanged.
REQ-020 Step tick: tick is high for exactly one cycle, in the cycle after the step event.
REQ-021 A run event and a step event in the same cycle: the run event is taken and the step event is discarded.
REQ-022 With DIVISOR=1, tick is high every cycle in RUN after the first RUN cycle.
REQ-023 Prescaler width is ceil(log2(DIVISOR)), minimum 1 bit; no overflow beyond DIVISOR-1 is permitted.
REQ-024 tick is never high in two consecutive cycles unless DIVISOR=1 and state is RUN.
REQ-025 Raw button to press-event latency: 2 + DB_CYCLES cycles after the first stable sampled level.

Reset
REQ-026 While rst=0 at a clk edge: state=IDLE, running=0, tick=0, prescaler=0, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-027 Reset asserted mid-RUN or mid-PAUSE: returns to IDLE on that edge and discards the frozen prescaler value; a button held through reset yields a press event only after DB_CYCLES stable samples following reset release.
REQ-028 No tick is issued in the cycle that reset is asserted or in the first cycle after release.

Verification (DIVISOR=4, DB_CYCLES=3)
REQ-029 Reset, then hold btn_run high for 10 cycles -> running rises 6 cycles after btn_run rises; ticks appear at 4, 8 and 12 cycles after running rises.
REQ-030 btn_run pulsed high for 2 cycles only (bounce) -> no press event; state stays IDLE; tick stays 0.
REQ-031 In RUN, pause 2 cycles after a tick, wait 20 cycles, then resume -> no tick during PAUSE; the next tick comes 2 cycles after re-entering RUN.
REQ-032 In IDLE, three separate debounced btn_step presses -> exactly three single-cycle ticks; state stays IDLE.
REQ-033 btn_run and btn_step rise in the same cycle and are held, from IDLE -> RUN entered; no step tick issued.
REQ-034 rst driven low for one cycle while in RUN with the prescaler at 3 -> state=00, tick=0 on that edge; after release, btn_run is required to return to RUN, and the first tick follows 4 cycles later.
